return_addr_stack: RTL and testbench
====================================

Name: return_addr_stack

Overview:
- Fetch-side return-address stack (RAS) that predicts jalr return targets.
- The execute-side operand select resolves a jalr as rs1+imm, while the RAS supplies the predicted target to fetch one stage earlier.
- Decode pushes PC+4 on call-type jal/jalr (rd = x1/x5) and pops on return-type jalr (rs1 = x1/x5, rd ≠ rs1).
- Circular buffer: on overflow the oldest entry is overwritten.

Parameters:
size, 32, address width in bits
DEPTH, 8, number of entries; power of two, at least 2

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
push_en  input  1  push push_addr this cycle (call)
push_addr  input  size  return address (PC+4) to push
pop_en  input  1  pop top entry this cycle (return)
flush_en  input  1  clear stack (pipeline-wide flush / context switch)
top_addr  output  size  predicted return target = current top entry
top_valid  output  1  stack non-empty
count  output  $clog2(DEPTH)+1  number of valid entries, 0..DEPTH
full  output  1  count == DEPTH
empty  output  1  count == 0

Behaviour:
- Reset (rst=1 at posedge): tos pointer=0, count=0. Entry memory is not reset. Outputs after reset: top_addr=0, top_valid=0, count=0, full=0, empty=1.
- State: tos pointer [$clog2(DEPTH)-1:0] points to the next free slot; top entry = mem[tos-1], modulo DEPTH.
- Outputs are combinational from registered state:
  - top_addr = mem[tos-1] when count>0, else 0.
  - top_valid = (count != 0).
- Updates take effect at posedge. New top is visible the cycle after push (1-cycle latency).
- Priority: rst > flush_en > push/pop.
- flush_en: count←0, tos unchanged, push/pop ignored.
- Push only:
  - mem[tos]←push_addr, tos←tos+1 (wraps).
  - count←min(count+1, DEPTH).
  - When full, the oldest entry is silently overwritten; count stays DEPTH.
- Pop only:
  - If count>0: tos←tos-1 (wraps), count←count-1.
  - If empty: no state change (underflow ignored).
- Push and pop in the same cycle (coroutine jalr):
  - If count>0: mem[tos-1]←push_addr, tos and count unchanged.
  - If empty: behaves as push only.
- No read-during-write bypass: top_addr in the push cycle shows the pre-push top.

Optional Feature:
Macro RAS_CHECKPOINT_EN, for branch-mispredict recovery.
- With the macro defined, add ports:
  - ckpt_save  input  1
  - ckpt_restore  input  1
  - ckpt_tos  output  $clog2(DEPTH)
  - ckpt_count  output  $clog2(DEPTH)+1
- ckpt_save: at posedge, the shadow registers capture the *post-update* tos/count, i.e. the state including any same-cycle push/pop.
- ckpt_restore: tos←shadow tos, count←shadow count. Same-cycle push/pop is ignored. Entry contents are not restored.
- Priority: rst > flush_en > ckpt_restore > push/pop.
- Reset clears the shadow registers to 0. flush_en also clears shadow count.
- Without the macro: no shadow registers and no extra ports; behaviour exactly as above.

Test Plan:
- Reset: assert rst 2 cycles, then idle. Required: top_valid=0, top_addr=0, count=0, empty=1, full=0.
- LIFO order: push 0x100, 0x104, 0x108 on consecutive cycles, then pop 3. Required: top_addr reads 0x108, 0x104, 0x100 before each pop; empty=1 afterwards.
- Overflow, DEPTH=8: push 0x1000+4*i for i=0..9. Required: count=8, full=1; 8 pops yield 0x1024 down to 0x1008; 9th pop leaves count=0 with no change.
- Simultaneous push/pop:
  - With top 0x200 (count=2): push_en=pop_en=1, push_addr=0x300. Required: top_addr=0x300, count=2.
  - When empty, same stimulus: count=1, top_addr=0x300.
- Flush: push 3 entries, then assert flush_en together with push_en. Required: count=0, top_valid=0 next cycle.
- RAS_CHECKPOINT_EN:
  - Push 0xA0, 0xA4; ckpt_save; pop; push 0xB0; ckpt_restore with pop_en=1.
  - Required: count=2, top_addr=0xB0. Contents not restored; slot overwritten; pop ignored.

Source files
------------

// File: rtl/return_addr_stack.sv
// Return-address stack for fetch-side prediction of jalr return targets.
// Circular buffer: a push on a full stack overwrites the oldest entry.
// Optional build macro RAS_CHECKPOINT_EN adds shadow tos/count registers
// for branch-mispredict recovery (save/restore of the stack pointers only).
module return_addr_stack #(
  parameter int size  = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_en,
  input  logic [size-1:0]          push_addr,
  input  logic                     pop_en,
  input  logic                     flush_en,
`ifdef RAS_CHECKPOINT_EN
  input  logic                     ckpt_save,
  input  logic                     ckpt_restore,
  output logic [$clog2(DEPTH)-1:0] ckpt_tos,
  output logic [$clog2(DEPTH):0]   ckpt_count,
`endif
  output logic [size-1:0]          top_addr,
  output logic                     top_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [size-1:0] r_mem [DEPTH];
  logic [PW-1:0]   r_tos;
  logic [CW-1:0]   r_count;

  logic [PW-1:0]   w_top_idx;
  logic [PW-1:0]   w_tos_nxt;
  logic [CW-1:0]   w_count_nxt;
  logic            w_wr_en;
  logic [PW-1:0]   w_wr_idx;
  logic            w_nonempty;
  logic            w_full;

`ifdef RAS_CHECKPOINT_EN
  logic [PW-1:0]   r_ckpt_tos;
  logic [CW-1:0]   r_ckpt_count;
`endif

  assign w_top_idx  = r_tos - PTR_ONE;
  assign w_nonempty = (r_count != '0);
  assign w_full     = (r_count == FULL_CNT);

  // Next pointer/count and entry write, in priority order flush > restore > push/pop.
  always_comb begin
    w_tos_nxt   = r_tos;
    w_count_nxt = r_count;
    w_wr_en     = 1'b0;
    w_wr_idx    = r_tos;
    if (flush_en) begin
      w_count_nxt = '0;
`ifdef RAS_CHECKPOINT_EN
    end else if (ckpt_restore) begin
      w_tos_nxt   = r_ckpt_tos;
      w_count_nxt = r_ckpt_count;
`endif
    end else if (push_en && pop_en && w_nonempty) begin
      // coroutine jalr: replace the top entry in place
      w_wr_en  = 1'b1;
      w_wr_idx = w_top_idx;
    end else if (push_en) begin
      w_wr_en     = 1'b1;
      w_wr_idx    = r_tos;
      w_tos_nxt   = r_tos + PTR_ONE;
      w_count_nxt = w_full ? r_count : r_count + CNT_ONE;
    end else if (pop_en && w_nonempty) begin
      w_tos_nxt   = w_top_idx;
      w_count_nxt = r_count - CNT_ONE;
    end
  end

  // Stack pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tos   <= '0;
      r_count <= '0;
    end else begin
      r_tos   <= w_tos_nxt;
      r_count <= w_count_nxt;
    end
  end

  // Entry storage; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (!rst && w_wr_en) begin
      r_mem[w_wr_idx] <= push_addr;
    end
  end

`ifdef RAS_CHECKPOINT_EN
  // Shadow pointers capture the post-update state so a same-cycle push/pop is included.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ckpt_tos   <= '0;
      r_ckpt_count <= '0;
    end else if (flush_en) begin
      r_ckpt_count <= '0;
    end else if (ckpt_save) begin
      r_ckpt_tos   <= w_tos_nxt;
      r_ckpt_count <= w_count_nxt;
    end
  end

  assign ckpt_tos   = r_ckpt_tos;
  assign ckpt_count = r_ckpt_count;
`endif

  assign top_addr  = w_nonempty ? r_mem[w_top_idx] : '0;
  assign top_valid = w_nonempty;
  assign count     = r_count;
  assign full      = w_full;
  assign empty     = !w_nonempty;

endmodule

// File: tb/tb_return_addr_stack.sv
// Self-checking bench for return_addr_stack: directed vector table,
// hand-written multi-cycle sequences and randomized traffic against a
// queue-based stack model.
module tb_return_addr_stack;
  localparam int SZ = 32;
  localparam int DP = 8;

  logic          clk = 1'b0;
  logic          rst, push_en, pop_en, flush_en;
  logic [SZ-1:0] push_addr;
  logic [SZ-1:0] top_addr;
  logic          top_valid, full, empty;
  logic [3:0]    count;
`ifdef RAS_CHECKPOINT_EN
  logic          ckpt_save, ckpt_restore;
  logic [2:0]    ckpt_tos;
  logic [3:0]    ckpt_count;
`endif

  return_addr_stack #(.size(SZ), .DEPTH(DP)) dut (
    .clk(clk), .rst(rst), .push_en(push_en), .push_addr(push_addr),
    .pop_en(pop_en), .flush_en(flush_en),
`ifdef RAS_CHECKPOINT_EN
    .ckpt_save(ckpt_save), .ckpt_restore(ckpt_restore),
    .ckpt_tos(ckpt_tos), .ckpt_count(ckpt_count),
`endif
    .top_addr(top_addr), .top_valid(top_valid), .count(count),
    .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit          push;
    bit          pop;
    bit          flush;
    logic [31:0] addr;
    int          exp_cnt;
    logic [31:0] exp_top;
  } vec_t;
  vec_t vecs[$];

  logic [31:0] model[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_state(input string name, input int exp_cnt, input logic [31:0] exp_top);
    check({name, ".count"}, 32'(count), 32'(exp_cnt));
    check({name, ".top_addr"}, top_addr, exp_top);
    check({name, ".top_valid"}, 32'(top_valid), 32'(exp_cnt != 0));
    check({name, ".full"}, 32'(full), 32'(exp_cnt == DP));
    check({name, ".empty"}, 32'(empty), 32'(exp_cnt == 0));
  endtask

  task automatic drive(input bit p, input bit o, input bit f, input logic [31:0] a);
    push_en = p; pop_en = o; flush_en = f; push_addr = a;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drive(0, 0, 0, 32'h0);
`ifdef RAS_CHECKPOINT_EN
    ckpt_save = 0; ckpt_restore = 0;
`endif
  endtask

  function automatic vec_t mk(bit p, bit o, bit f, logic [31:0] a, int c, logic [31:0] t);
    vec_t v;
    v.push = p; v.pop = o; v.flush = f; v.addr = a; v.exp_cnt = c; v.exp_top = t;
    return v;
  endfunction

  // Reference: stack of live entries, oldest at the front.
  task automatic model_step(input bit p, input bit o, input bit f, input logic [31:0] a);
    if (f) model.delete();
    else if (p && o && model.size() > 0) model[model.size()-1] = a;
    else if (p) begin
      model.push_back(a);
      if (model.size() > DP) void'(model.pop_front());
    end else if (o && model.size() > 0) void'(model.pop_back());
  endtask

  initial begin
    rst = 1; drive(0, 0, 0, 32'h0);
`ifdef RAS_CHECKPOINT_EN
    ckpt_save = 0; ckpt_restore = 0;
`endif
    @(posedge clk); @(posedge clk); #1;
    rst = 0;
    tick();
    check_state("reset", 0, 32'h0);

    // LIFO, underflow, simultaneous push/pop and flush as a vector table
    vecs.push_back(mk(1, 0, 0, 32'h100, 1, 32'h100));
    vecs.push_back(mk(1, 0, 0, 32'h104, 2, 32'h104));
    vecs.push_back(mk(1, 0, 0, 32'h108, 3, 32'h108));
    vecs.push_back(mk(0, 1, 0, 32'h0,   2, 32'h104));
    vecs.push_back(mk(0, 1, 0, 32'h0,   1, 32'h100));
    vecs.push_back(mk(0, 1, 0, 32'h0,   0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h0,   0, 32'h0));
    vecs.push_back(mk(1, 1, 0, 32'h300, 1, 32'h300));
    vecs.push_back(mk(1, 0, 0, 32'h200, 2, 32'h200));
    vecs.push_back(mk(1, 1, 0, 32'h300, 2, 32'h300));
    vecs.push_back(mk(0, 1, 0, 32'h0,   1, 32'h300));
    vecs.push_back(mk(0, 1, 0, 32'h0,   0, 32'h0));
    vecs.push_back(mk(1, 0, 0, 32'h10,  1, 32'h10));
    vecs.push_back(mk(1, 0, 0, 32'h20,  2, 32'h20));
    vecs.push_back(mk(1, 0, 0, 32'h30,  3, 32'h30));
    vecs.push_back(mk(1, 0, 1, 32'h40,  0, 32'h0));
    vecs.push_back(mk(1, 0, 0, 32'h50,  1, 32'h50));
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].push, vecs[i].pop, vecs[i].flush, vecs[i].addr);
      tick();
      check_state($sformatf("vec%0d", i), vecs[i].exp_cnt, vecs[i].exp_top);
    end

    // No bypass: during the push cycle the old top is still shown
    drive(1, 0, 0, 32'h60);
    #1;
    check("nobypass.top_addr", top_addr, 32'h50);
    tick();
    check("nobypass.after", top_addr, 32'h60);

    // Overflow: ten pushes into eight slots, then drain
    drive(0, 0, 1, 32'h0); tick();
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 0, 32'h1000 + 4 * i);
      tick();
    end
    check_state("ovf.full", 8, 32'h1024);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("ovf.pop%0d", k), top_addr, 32'h1024 - 4 * k);
      drive(0, 1, 0, 32'h0);
      tick();
    end
    check_state("ovf.drained", 0, 32'h0);
    drive(0, 1, 0, 32'h0); tick();
    check_state("ovf.underflow", 0, 32'h0);

`ifdef RAS_CHECKPOINT_EN
    drive(1, 0, 0, 32'hA0); tick();
    drive(1, 0, 0, 32'hA4); tick();
    ckpt_save = 1; tick();
    check("ckpt.saved_cnt", 32'(ckpt_count), 32'd2);
    drive(0, 1, 0, 32'h0); tick();
    drive(1, 0, 0, 32'hB0); tick();
    drive(0, 1, 0, 32'h0); ckpt_restore = 1; tick();
    check_state("ckpt.restore", 2, 32'hB0);
    drive(0, 0, 1, 32'h0); tick();
    check("ckpt.flush_cnt", 32'(ckpt_count), 32'd0);
`endif

    // Randomized traffic against the queue model
    drive(0, 0, 1, 32'h0); tick();
    model.delete();
    for (int i = 0; i < 400; i++) begin
      bit p, o, f;
      logic [31:0] a;
      p = ($urandom_range(0, 99) < 55);
      o = ($urandom_range(0, 99) < 45);
      f = ($urandom_range(0, 99) < 3);
      a = {$urandom, 2'b00} ;
      drive(p, o, f, a);
      tick();
      model_step(p, o, f, a);
      check_state($sformatf("rand%0d", i), model.size(),
                  (model.size() > 0) ? model[model.size()-1] : 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
